data_mem_unit: RTL
==================

// Module: data_mem_unit
// PURPOSE
//  Parametrised byte-addressable data memory with a valid/ready request port and a registered response port.
//  Sits behind the multi-cycle core's load/store stage.
//  Supports byte, half-word and word accesses with sign/zero extension on reads.
//  Misaligned accesses that cross a word boundary are split into two word beats; out-of-range and illegal requests are flagged as errors.
// PARAMETERS
//  DEPTH_WORDS       64  storage depth in 32-bit words; byte range is 0..4*DEPTH_WORDS-1
//  ALLOW_MISALIGNED  1   1: split word-crossing accesses into two beats; 0: flag them as errors
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid & req_ready at a rising edge
//  req_wr     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, LSB-aligned
//  req_size   in   2   00 byte, 01 half word, 10 word, 11 illegal
//  req_sx     in   1   loads only: 1 = sign-extend, 0 = zero-extend
//  rsp_valid  out  1   one-cycle response pulse
//  rsp_rdata  out  32  load data, extended; 0 for stores and errors
//  rsp_err    out  1   valid with rsp_valid: request was rejected, memory untouched
// BEHAVIOUR
//  Storage and endianness
//   - Storage is mem[DEPTH_WORDS] x 32 bits, little-endian.
//   - Byte b of the address space lives in mem[b>>2][8*(b%4)+:8].
//   - Storage contents are NOT reset; only control state and outputs are.
//  Reset values (while rst=0)
//   - State = IDLE; req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
//   - req_ready rises in the first cycle after rst deasserts.
//  FSM: IDLE -> BEAT0 -> [BEAT1] -> RESP -> IDLE
//   - IDLE: req_ready=1. On accept, latch all req_* and go to BEAT0. req_ready=0 in every other state.
//   - BEAT0: evaluate the error checks below.
//     - On error: no storage access; go to RESP with err=1.
//     - Otherwise access word w0=addr>>2. Go to BEAT1 if (addr%4)+nbytes>4 (nbytes = 1/2/4), else RESP.
//   - BEAT1: access word w0+1 for the remaining upper bytes; go to RESP.
//   - RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata and rsp_err; then IDLE.
//  Latency and throughput
//   - rsp_valid is high in the 3rd cycle after the accept edge for a single-beat access, the 4th for a split access.
//   - Throughput is 1 request per 3 (4) cycles. No response back-pressure.
//  Error conditions (checked entirely before any write, so an erroring request writes nothing)
//   - req_size==11.
//   - addr+nbytes-1 > 4*DEPTH_WORDS-1; a split whose second word is out of range counts.
//   - Word-crossing access when ALLOW_MISALIGNED=0.
//  Stores
//   - Per-beat byte enables derived from addr%4 and size. Bytes outside the enables are unchanged.
//   - rsp_rdata=0 for stores.
//  Loads
//   - Bytes are assembled across beats, then extended per req_sx:
//     - byte: bit 7 replicated
//     - half: bit 15 replicated
//     - word: unchanged
//  Reset mid-operation
//   - An asynchronous reset returns the FSM to IDLE and drops any pending response.
//   - A split store interrupted after BEAT0 leaves the low bytes written and the high bytes unwritten.
//   - Software must not rely on atomicity across reset.
//  req_* inputs are ignored while req_ready=0.
// TESTING
//  1. Reset: rst=0 mid-BEAT1 -> rsp_valid=0 and req_ready=0 immediately; req_ready=1 one cycle after release.
//  2. SW addr 0x10, data 0xDEADBEEF, then LB sx=1 addr 0x13 -> rdata 0xFFFFFFDE.
//     Then LHU addr 0x10 -> 0x0000BEEF.
//  3. Split (ALLOW_MISALIGNED=1): SW 0x11223344 at 0x06.
//     -> bytes 6..9 = 44,33,22,11; rsp_valid 4 cycles after accept.
//     LW addr 0x06 -> 0x11223344.
//  4. Misaligned reject (ALLOW_MISALIGNED=0): SH 0xABCD at 0x07 -> err=1, bytes 7 and 8 unchanged.
//     SH at 0x06 -> err=0.
//  5. Range: DEPTH_WORDS=64.
//     - LW at 0xFC -> err=0.
//     - LW at 0xFE -> err=1, rdata=0.
//     - SB at 0x100 -> err=1, no write.
//  6. Illegal size: req_size=11 -> err=1.
//     Back-to-back req_valid held high -> accepts exactly every 3rd cycle; no request lost or duplicated.

Source files
------------

// File: rtl/data_mem_unit.sv
// Byte-addressable data memory behind the load/store stage. A request is accepted in IDLE,
// then executed as one or two word beats. One registered response pulse follows.
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS      = 64,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_sx,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LastByte = 33'(4 * DEPTH_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

  state_e      r_state, w_state_d;
  logic        r_ready;
  logic        r_wr, r_sx, r_err;
  logic [31:0] r_addr, r_wdata;
  logic [1:0]  r_size;
  logic [63:0] r_raw;  // beat0 word in [31:0], beat1 word in [63:32]
  logic        r_rsp_valid, r_rsp_err;
  logic [31:0] r_rsp_rdata;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic [1:0]    w_off;
  logic [4:0]    w_shift;
  logic [2:0]    w_nbytes;
  logic [3:0]    w_mask;
  logic [7:0]    w_be8;
  logic [63:0]   w_wd64;
  logic [32:0]   w_last;
  logic          w_cross, w_err;
  logic [AW-1:0] w_widx0, w_widx1, w_beat_idx;
  logic [3:0]    w_beat_be;
  logic [31:0]   w_beat_wd;
  logic          w_we;
  logic [31:0]   w_shifted, w_load;

  assign w_accept = i_req_valid & r_ready;
  assign w_off    = r_addr[1:0];
  assign w_shift  = {w_off, 3'b000};

  // Access width and byte mask from the latched size; illegal size is flagged separately.
  always_comb begin
    w_nbytes = 3'd4;
    w_mask   = 4'b1111;
    unique case (r_size)
      2'b00:   begin w_nbytes = 3'd1; w_mask = 4'b0001; end
      2'b01:   begin w_nbytes = 3'd2; w_mask = 4'b0011; end
      default: begin w_nbytes = 3'd4; w_mask = 4'b1111; end
    endcase
  end

  assign w_be8   = {4'd0, w_mask} << w_off;
  assign w_wd64  = {32'd0, r_wdata} << w_shift;
  assign w_last  = {1'b0, r_addr} + {30'd0, w_nbytes} - 33'd1;
  assign w_cross = ({1'b0, w_off} + w_nbytes) > 3'd4;
  // The full-range check also covers a split whose second word falls off the end.
  assign w_err   = (r_size == 2'b11) || (w_last > LastByte) || (!ALLOW_MISALIGNED && w_cross);

  assign w_widx0    = r_addr[AW+1:2];
  assign w_widx1    = w_widx0 + AW'(1);
  assign w_beat_idx = (r_state == StBeat1) ? w_widx1 : w_widx0;
  assign w_beat_be  = (r_state == StBeat1) ? w_be8[7:4] : w_be8[3:0];
  assign w_beat_wd  = (r_state == StBeat1) ? w_wd64[63:32] : w_wd64[31:0];
  assign w_we       = r_wr && (((r_state == StBeat0) && !w_err) || (r_state == StBeat1));

  // Align the assembled bytes to bit 0 and extend to 32 bits.
  assign w_shifted = 32'(r_raw >> w_shift);
  always_comb begin
    w_load = w_shifted;
    unique case (r_size)
      2'b00:   w_load = {{24{r_sx & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{16{r_sx & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // Next-state: errors skip storage entirely, word-crossing accesses take a second beat.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_d = StBeat0;
      StBeat0: w_state_d = (!w_err && w_cross) ? StBeat1 : StResp;
      StBeat1: w_state_d = StResp;
      StResp:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Control state, request latch and load-byte assembly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_ready <= 1'b0;
      r_wr    <= 1'b0;
      r_sx    <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_size  <= 2'b00;
      r_raw   <= 64'd0;
    end else begin
      r_state <= w_state_d;
      r_ready <= (w_state_d == StIdle);
      if (w_accept) begin
        r_wr    <= i_req_wr;
        r_sx    <= i_req_sx;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_size  <= i_req_size;
      end
      if (r_state == StBeat0) begin
        r_err <= w_err;
        if (!w_err) r_raw <= {32'd0, r_mem[w_widx0]};
      end
      if (r_state == StBeat1) r_raw[63:32] <= r_mem[w_widx1];
    end
  end

  // Registered response: a single-cycle pulse on leaving RESP; data zeroed for stores/errors.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end else if (r_state == StResp) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= r_err;
      r_rsp_rdata <= (r_err || r_wr) ? 32'd0 : w_load;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
    end
  end

  // Storage is not reset; byte-enabled write for the current beat.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_beat_be[b]) r_mem[w_beat_idx][8*b +: 8] <= w_beat_wd[8*b +: 8];
      end
    end
  end

  assign o_req_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_rsp_rdata;

endmodule
